// File: rtl/ieu_fwd.sv
// rtl/ieu_fwd.sv - integer execution unit with writeback delay line and operand forwarding
// Issues one RV32I-style instruction per cycle with zero issue latency.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   instr_valid        instr/curr_pc/inc_pc valid this cycle
//   instr              instruction bits [31:2]
//   curr_pc, inc_pc    PC of instr and PC+4
//   rd_data            writeback data for the instruction issued WB_DELAY cycles earlier
//   stall, issue       hold request to fetch; instruction accepted this cycle
//   je, ja             jump/branch taken (issue-qualified) and its target
//   result, reg_out    ALU result (inc_pc for jumps); forwarded rs2 (store data)
//   mm_we, passthrough store enable; load request (both issue-qualified)
//   stall_cnt          saturating count of stalled valid cycles
module ieu_fwd #(
  parameter int XLEN     = 32,
  parameter int WB_DELAY = 2,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [29:0]      instr,
  input  logic [XLEN-1:0]  curr_pc,
  input  logic [XLEN-1:0]  inc_pc,
  input  logic [XLEN-1:0]  rd_data,
  output logic             stall,
  output logic             issue,
  output logic             je,
  output logic [XLEN-1:0]  ja,
  output logic [XLEN-1:0]  result,
  output logic [XLEN-1:0]  reg_out,
  output logic             mm_we,
  output logic             passthrough,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int SH = $clog2(XLEN);

  // Decode
  logic [31:0] ir;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        f7b5;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_opi, is_op;
  logic        writes_rd, use_rs1, use_rs2;

  assign ir   = {instr, 2'b11};
  assign opc  = ir[6:0];
  assign rd   = ir[11:7];
  assign f3   = ir[14:12];
  assign rs1  = ir[19:15];
  assign rs2  = ir[24:20];
  assign f7b5 = ir[30];

  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);
  assign is_br    = (opc == 7'b1100011);
  assign is_load  = (opc == 7'b0000011);
  assign is_store = (opc == 7'b0100011);
  assign is_opi   = (opc == 7'b0010011);
  assign is_op    = (opc == 7'b0110011);

  // Writes to x0 never enter the delay line as producers.
  assign writes_rd = (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opi | is_op) & (rd != 5'd0);
  assign use_rs1   = ~(is_lui | is_auipc | is_jal);
  assign use_rs2   = is_op | is_store | is_br;

  // Immediates, sign-extended to XLEN
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  assign imm_i = {{(XLEN-11){ir[31]}}, ir[30:20]};
  assign imm_s = {{(XLEN-11){ir[31]}}, ir[30:25], ir[11:7]};
  assign imm_b = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm   = is_store ? imm_s :
                 is_br    ? imm_b :
                 (is_lui | is_auipc) ? imm_u :
                 is_jal   ? imm_j : imm_i;

  // Writeback delay line, stage 1 is the youngest in-flight instruction
  logic [WB_DELAY:1]           st_we, st_ld;
  logic [WB_DELAY:1][4:0]      st_rd;
  logic [WB_DELAY:1][XLEN-1:0] st_res;
  logic [XLEN-1:0]             irf [32];

  // Operand resolution; index 0 is rs1, index 1 is rs2
  logic [1:0][4:0]      rs_idx;
  logic [1:0][XLEN-1:0] rs_val;
  logic [1:0]           rs_haz;
  assign rs_idx[0] = rs1;
  assign rs_idx[1] = rs2;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rs_val[k] = (rs_idx[k] == 5'd0) ? '0 : irf[rs_idx[k]];
      rs_haz[k] = 1'b0;
      // Walk oldest to youngest so the lowest-index producer overrides.
      for (int i = WB_DELAY; i >= 1; i--) begin
        if (rs_idx[k] != 5'd0 && st_we[i] && st_rd[i] == rs_idx[k]) begin
          if (FWD_EN == 0) begin
            rs_haz[k] = 1'b1;
          end else if (i == WB_DELAY) begin
            rs_val[k] = rd_data;
            rs_haz[k] = 1'b0;
          end else if (st_ld[i]) begin
            rs_haz[k] = 1'b1;
          end else begin
            rs_val[k] = st_res[i];
            rs_haz[k] = 1'b0;
          end
        end
      end
    end
  end

  // ALU and branch unit
  logic [XLEN-1:0] op_a, op_b, alu_sum, alu_res;
  logic            taken;
  assign op_a    = is_lui ? '0 : (is_auipc | is_jal | is_br) ? curr_pc : rs_val[0];
  assign op_b    = is_op ? rs_val[1] : imm;
  assign alu_sum = op_a + op_b;

  always_comb begin
    alu_res = alu_sum;
    if (is_op | is_opi) begin
      case (f3)
        3'b000: alu_res = (is_op & f7b5) ? op_a - op_b : alu_sum;
        3'b001: alu_res = op_a << op_b[SH-1:0];
        3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
        3'b011: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
        3'b100: alu_res = op_a ^ op_b;
        3'b101: alu_res = f7b5 ? $signed(op_a) >>> op_b[SH-1:0] : op_a >> op_b[SH-1:0];
        3'b110: alu_res = op_a | op_b;
        3'b111: alu_res = op_a & op_b;
      endcase
    end
  end

  always_comb begin
    case (f3)
      3'b000:  taken = (rs_val[0] == rs_val[1]);
      3'b001:  taken = (rs_val[0] != rs_val[1]);
      3'b100:  taken = ($signed(rs_val[0]) <  $signed(rs_val[1]));
      3'b101:  taken = ($signed(rs_val[0]) >= $signed(rs_val[1]));
      3'b110:  taken = (rs_val[0] <  rs_val[1]);
      3'b111:  taken = (rs_val[0] >= rs_val[1]);
      default: taken = 1'b0;
    endcase
  end

  // Outputs
  assign stall       = ~rst & instr_valid & ((use_rs1 & rs_haz[0]) | (use_rs2 & rs_haz[1]));
  assign issue       = ~rst & instr_valid & ~stall;
  assign je          = issue & (is_jal | is_jalr | (is_br & taken));
  assign ja          = is_jalr ? {alu_sum[XLEN-1:1], 1'b0} : alu_sum;
  assign result      = (is_jal | is_jalr) ? inc_pc : alu_res;
  assign reg_out     = rs_val[1];
  assign mm_we       = issue & is_store;
  assign passthrough = issue & is_load;

  // Delay line shift; a stalled or idle cycle injects a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      st_we  <= '0;
      st_ld  <= '0;
      st_rd  <= '0;
      st_res <= '0;
    end else begin
      st_we[1]  <= issue & writes_rd;
      st_ld[1]  <= passthrough & ~(is_jal | is_jalr) & ~mm_we;
      st_rd[1]  <= rd;
      st_res[1] <= result;
      for (int i = 2; i <= WB_DELAY; i++) begin
        st_we[i]  <= st_we[i-1];
        st_ld[i]  <= st_ld[i-1];
        st_rd[i]  <= st_rd[i-1];
        st_res[i] <= st_res[i-1];
      end
    end
  end

  // Register file is not reset; only the in-flight writebacks are dropped.
  always_ff @(posedge clk) begin
    if (!rst && st_we[WB_DELAY]) begin
      irf[st_rd[WB_DELAY]] <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/ieu_fwd.md
Name: ieu_fwd

Overview:
Second-generation integer execution unit. It issues one decoded instruction per cycle through idu/alu/jbu/irf and generalises the writeback delay line to WB_DELAY stages. RAW hazards are resolved by a forwarding network instead of blanket stalling. It stalls only for load-use hazards, adds a valid handshake and a stall performance counter, and sits between the fetch unit and the MMU.

Parameters:
XLEN, 32, datapath width.
WB_DELAY, 2, cycles from issue to the matching rd_data on the writeback port; legal range 1..8.
FWD_EN, 1, enables forwarding (1) or stall-until-writeback (0).
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
instr_valid  in  1  instr/pc fields valid this cycle.
instr  in  30  instruction bits [31:2].
curr_pc  in  XLEN  PC of instr.
inc_pc  in  XLEN  PC+4 of instr.
rd_data  in  XLEN  writeback data for the instruction issued WB_DELAY cycles earlier.
stall  out  1  instruction held; fetch must keep instr stable.
issue  out  1  instr_valid & ~stall & ~rst; instruction accepted this cycle.
je  out  1  jump/branch taken, qualified by issue.
ja  out  XLEN  jump target (ALU result).
result  out  XLEN  ALU result, or inc_pc for jumps.
reg_out  out  XLEN  forwarded rs2 value (store data).
mm_we  out  1  store enable, qualified by issue.
passthrough  out  1  load or ALU-return request, qualified by issue.
stall_cnt  out  CNT_W  saturating count of cycles with instr_valid & stall.

Behaviour:
- Delay line: stages 1..WB_DELAY, each holding {we, rd, is_load, res}.
  - Stage 0 is the current instruction. On each edge, stage i+1 <= stage i.
  - Stage 1 loads stage 0 when issue. Otherwise it loads a bubble (we=0).
  - res = result output at issue. is_load = passthrough & ~jump & ~mm_we.
- irf write port is driven from stage WB_DELAY (we, rd) with rd_data. irf reads are asynchronous and see the old value during a write cycle.
- Operand resolution, per rs1 and rs2 independently; x0 is never matched and always reads 0.
  - Search stages 1..WB_DELAY. The lowest index with we=1 and rd==rs wins (youngest producer).
  - Match at stage WB_DELAY: forward rd_data.
  - Match at stage i<WB_DELAY with is_load=0: forward stage res.
  - Match at stage i<WB_DELAY with is_load=1: hazard.
  - No match: irf data.
- FWD_EN=0: any match at any stage is a hazard, giving the original stall-until-written behaviour.
- stall = instr_valid & hazard on a source actually used by the instruction. rs2 is ignored when op2_imm and the instruction is not a store or branch. rs1 is ignored for LUI/AUIPC/JAL.
- Each stalled cycle inserts one bubble. A load-use stall lasts WB_DELAY-i cycles for a producer at stage i.
- Outputs are combinational from stage 0 plus forwarded operands; issue latency is 0 cycles. je, mm_we and passthrough are 0 whenever issue=0.
- Reset, while rst=1 on a clock edge:
  - All delay stage we/is_load are cleared to 0; res and rd are cleared to 0.
  - stall_cnt is cleared to 0.
  - issue, je, mm_we and passthrough are forced to 0; stall reads 0.
- Reset mid-operation: in-flight writebacks are discarded. rd_data arriving in the first WB_DELAY cycles after reset is not written, because the stages are bubbles.
- stall_cnt increments when instr_valid & stall and saturates at all-ones. It does not wrap.
- instr_valid=0 with no stall: a bubble enters the pipeline and the outputs are don't-care except the qualified strobes.

Test Plan:
1. WB_DELAY=2, FWD_EN=1. Issue addi x1,x0,5 then addi x2,x1,3 back-to-back -> no stall; second result=8; irf x2=8 two cycles later.
2. Issue lw x1 with rd_data=0x1234 at cycle+2, then add x2,x1,x1 -> stall=1 for exactly 1 cycle; add then issues with result=0x2468; stall_cnt=1.
3. Issue addi x0,x0,7 then addi x1,x0,1 -> no stall; result=1; x0 reads 0.
4. FWD_EN=0. Issue addi x1,x0,5 then add x2,x1,x1 -> stall for 2 cycles, then result=10.
5. addi x1,x0,4, then beq x1,x1,+16 at pc=0x100 -> je=1, ja=0x110 on the branch issue cycle. With instr_valid held low instead of the branch, je=0.
6. Assert rst for 1 cycle while lw x1 is in flight, then issue add x2,x1,x1 -> no stall. x1 keeps its pre-reset irf value, and stall_cnt=0. Also hold a stall 2^CNT_W+3 cycles -> stall_cnt saturates at 0xFFFF.
